// File: rtl/gesture_pkg.sv
// rtl/gesture_pkg.sv - shared timing constants and key FSM state type for the gesture front end
package gesture_pkg;

    // Debounce/long-press FSM states for one push-button
    typedef enum logic [1:0] {
        RELEASED   = 2'd0,
        PRESS_DB   = 2'd1,
        PRESSED    = 2'd2,
        RELEASE_DB = 2'd3
    } key_state_t;

    // System clock, shared by the conditioner and the power controller
    localparam int unsigned CLK_HZ = 100_000_000;

    // 20 ms of stable input before a level change is believed
    localparam int unsigned DEBOUNCE_DEFAULT = CLK_HZ / 50;

    // 3 s hold, measured from the accepted press, for a long-press pulse
    localparam int unsigned LONG_PRESS_DEFAULT = CLK_HZ * 3;

    // Power controller countdown (5 s), kept here so both blocks share one time base
    localparam int unsigned COUNTDOWN_SECONDS = 5;
    localparam int unsigned COUNTDOWN_TIME    = CLK_HZ * COUNTDOWN_SECONDS;

    // Default counter width; must hold LONG_PRESS_DEFAULT
    localparam int unsigned CNT_W_DEFAULT = 32;

endpackage

// File: rtl/gesture_key_conditioner_key_debounce.sv
// rtl/gesture_key_conditioner_key_debounce.sv - synchroniser, debounce FSM and hold counter for one button
module key_debounce
    import gesture_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_DEFAULT,
    parameter int unsigned LONG_PRESS_CYCLES = LONG_PRESS_DEFAULT,
    parameter int unsigned CNT_W             = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_long
);

    // Counter compare points, pre-sized to the counter width
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_PRESS_CYCLES);

    logic             r_sync_0;
    logic             r_sync_1;
    key_state_t       r_state;
    logic [CNT_W-1:0] r_db_cnt;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_level;

    key_state_t       w_state_nxt;
    logic [CNT_W-1:0] w_db_cnt_nxt;
    logic [CNT_W-1:0] w_hold_cnt_nxt;
    logic [CNT_W-1:0] w_hold_inc;
    logic             w_level_nxt;
    logic             w_press;
    logic             w_long;
    logic             w_s_btn;

    assign w_s_btn = r_sync_1;

    // Two-flop synchroniser for the asynchronous, bouncy pin
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync_0 <= 1'b0;
            r_sync_1 <= 1'b0;
        end else begin
            r_sync_0 <= i_btn;
            r_sync_1 <= r_sync_0;
        end
    end

    // FSM state, debounce counter, hold counter and debounced level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= RELEASED;
            r_db_cnt   <= '0;
            r_hold_cnt <= '0;
            r_level    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_db_cnt   <= w_db_cnt_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_level    <= w_level_nxt;
        end
    end

    // Hold counter keeps running through a release glitch so long-press timing
    // is measured from the accepted press, and saturates so the long pulse fires once
    assign w_hold_inc = (r_hold_cnt == LONG_SAT) ? r_hold_cnt : (r_hold_cnt + CNT_ONE);

    // Next-state logic plus the raw press/long pulses (registered in the top)
    always_comb begin
        w_state_nxt    = r_state;
        w_db_cnt_nxt   = r_db_cnt;
        w_hold_cnt_nxt = r_hold_cnt;
        w_level_nxt    = r_level;
        w_press        = 1'b0;
        w_long         = 1'b0;

        unique case (r_state)
            RELEASED: begin
                w_hold_cnt_nxt = '0;
                w_level_nxt    = 1'b0;
                if (w_s_btn) begin
                    w_state_nxt  = PRESS_DB;
                    w_db_cnt_nxt = CNT_ONE;
                end else begin
                    w_db_cnt_nxt = '0;
                end
            end

            PRESS_DB: begin
                if (!w_s_btn) begin
                    w_state_nxt  = RELEASED;
                    w_db_cnt_nxt = '0;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nxt    = PRESSED;
                    w_level_nxt    = 1'b1;
                    w_press        = 1'b1;
                    w_db_cnt_nxt   = '0;
                    w_hold_cnt_nxt = '0;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + CNT_ONE;
                end
            end

            PRESSED: begin
                w_hold_cnt_nxt = w_hold_inc;
                w_long         = (r_hold_cnt == LONG_LAST);
                if (!w_s_btn) begin
                    w_state_nxt  = RELEASE_DB;
                    w_db_cnt_nxt = CNT_ONE;
                end
            end

            RELEASE_DB: begin
                w_hold_cnt_nxt = w_hold_inc;
                w_long         = (r_hold_cnt == LONG_LAST);
                if (w_s_btn) begin
                    w_state_nxt  = PRESSED;
                    w_db_cnt_nxt = '0;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nxt    = RELEASED;
                    w_level_nxt    = 1'b0;
                    w_db_cnt_nxt   = '0;
                    w_hold_cnt_nxt = '0;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + CNT_ONE;
                end
            end

            default: begin
                w_state_nxt    = RELEASED;
                w_db_cnt_nxt   = '0;
                w_hold_cnt_nxt = '0;
                w_level_nxt    = 1'b0;
            end
        endcase
    end

    assign o_level = r_level;
    assign o_press = w_press;
    assign o_long  = w_long;

endmodule

// File: rtl/gesture_key_conditioner.sv
// rtl/gesture_key_conditioner.sv - two debounced keys with press arbitration for the gesture controller
module gesture_key_conditioner
    import gesture_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_DEFAULT,
    parameter int unsigned LONG_PRESS_CYCLES = LONG_PRESS_DEFAULT,
    parameter int unsigned CNT_W             = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic left_btn,
    input  logic right_btn,
    output logic left_key,
    output logic right_key,
    output logic left_level,
    output logic right_level,
    output logic left_long,
    output logic right_long,
    output logic conflict
);

    logic w_left_press;
    logic w_right_press;
    logic w_left_long;
    logic w_right_long;
    logic w_left_level;
    logic w_right_level;

    logic r_left_key;
    logic r_right_key;
    logic r_left_long;
    logic r_right_long;
    logic r_conflict;

    key_debounce #(
        .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
        .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
        .CNT_W             (CNT_W)
    ) u_left (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (left_btn),
        .o_level (w_left_level),
        .o_press (w_left_press),
        .o_long  (w_left_long)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
        .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
        .CNT_W             (CNT_W)
    ) u_right (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (right_btn),
        .o_level (w_right_level),
        .o_press (w_right_press),
        .o_long  (w_right_long)
    );

    // Arbitration stage: simultaneous presses are suppressed and flagged as a conflict,
    // so downstream never sees both keys pulse together; long pulses pass through
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_left_key   <= 1'b0;
            r_right_key  <= 1'b0;
            r_conflict   <= 1'b0;
            r_left_long  <= 1'b0;
            r_right_long <= 1'b0;
        end else begin
            r_left_key   <= w_left_press & ~w_right_press;
            r_right_key  <= w_right_press & ~w_left_press;
            r_conflict   <= w_left_press & w_right_press;
            r_left_long  <= w_left_long;
            r_right_long <= w_right_long;
        end
    end

    assign left_key    = r_left_key;
    assign right_key   = r_right_key;
    assign conflict    = r_conflict;
    assign left_long   = r_left_long;
    assign right_long  = r_right_long;
    assign left_level  = w_left_level;
    assign right_level = w_right_level;

endmodule
